// File: rtl/sin_sched_pkg.sv
// Shared types for the sin unit scheduler.
// Holds the FSM state encoding, operand widths and the latched job bundle.
package sin_sched_pkg;

    localparam int FLOAT_W = 32;
    localparam int PREC_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_WAIT,
        S_RESPOND
    } sched_state_t;

    typedef struct packed {
        logic [FLOAT_W-1:0] theta;
        logic [PREC_W-1:0]  prec;
    } job_t;

endpackage

// File: rtl/sin_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), last (previous winner) -> grant (one-hot), idx.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic hit;

    // First pass looks above last, second pass wraps around to the bottom.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i] && (i > int'(last))) begin
                hit      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && req[i]) begin
                hit      = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sin_sched.sv
// Shares one iterative sin unit between NREQ requesters, round-robin.
// Ports: req_* request side, rsp_* response pulse, sin_* unit control.
module sin_sched
    import sin_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [FLOAT_W*NREQ-1:0] req_theta,
    input  logic [PREC_W*NREQ-1:0]  req_prec,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [FLOAT_W-1:0]      rsp_result,
    output logic                    rsp_err,
    output logic                    sin_reset,
    output logic [FLOAT_W-1:0]      sin_theta,
    output logic [PREC_W-1:0]       sin_prec,
    input  logic                    sin_done,
    input  logic [FLOAT_W-1:0]      sin_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    sched_state_t state, state_nx;

    logic [NREQ-1:0]    grant;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      owner;
    job_t               job_q;
    job_t               job_sel;
    logic [FLOAT_W-1:0] result_q;
    logic               err_q;
    logic [CW-1:0]      cnt;
    logic               hs;
    logic               tmo_hit;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant),
        .idx   (gidx)
    );

    // Ready is only offered in IDLE and never while reset is held.
    assign req_ready = (state == S_IDLE && !reset) ? grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign tmo_hit   = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        job_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                job_sel.theta = req_theta[i*FLOAT_W +: FLOAT_W];
                job_sel.prec  = req_prec[i*PREC_W +: PREC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (hs) state_nx = S_LAUNCH;
            S_LAUNCH:  state_nx = S_SETTLE;
            S_SETTLE:  state_nx = S_WAIT;
            S_WAIT:    if (sin_done || tmo_hit) state_nx = S_RESPOND;
            S_RESPOND: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            owner      <= '0;
            job_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (hs) begin
                last_grant <= gidx;
                owner      <= gidx;
                job_q      <= job_sel;
            end
            // SETTLE clears so the first WAIT cycle sees zero.
            if (state == S_SETTLE)    cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt + CW'(1);
            // done takes priority over a coincident timeout.
            if (state == S_WAIT) begin
                if (sin_done) begin
                    result_q <= sin_result;
                    err_q    <= 1'b0;
                end else if (tmo_hit) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    assign rsp_valid  = (state == S_RESPOND && !reset)
                      ? (NREQ'(1) << owner) : '0;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign sin_reset  = reset | (state == S_LAUNCH);
    assign sin_theta  = job_q.theta;
    assign sin_prec   = job_q.prec;

endmodule

// File: tb/tb_sin_sched.sv
// Testbench for sin_sched with a latency-programmable sin stub.
// Timing of each operation is predicted from handshake and stub latency.
module tb_sin_sched;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [32*N-1:0] req_theta;
    logic [4*N-1:0]  req_prec;
    logic [31:0]     rsp_result, sin_theta, sin_result;
    logic            rsp_err, sin_reset, sin_done;
    logic [3:0]      sin_prec;

    logic [31:0]     th_a [N];
    logic [3:0]      pr_a [N];
    logic [N-1:0]    vld = '0;
    logic [N-1:0]    sticky = '0;
    int              nvec = 0;
    int              nerr = 0;
    int              last_g = N - 1;
    int              stub_lat = 1;
    int              scnt = 0;
    bit              stale = 1'b0;

    always #5 clk = ~clk;

    sin_sched #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_theta  (req_theta),
        .req_prec   (req_prec),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .sin_reset  (sin_reset),
        .sin_theta  (sin_theta),
        .sin_prec   (sin_prec),
        .sin_done   (sin_done),
        .sin_result (sin_result)
    );

    function automatic logic [31:0] sine_ref(input logic [31:0] t);
        case (t)
            32'h00000000: return 32'h00000000;
            32'h3f800000: return 32'h3f576aa5;
            32'h3f99999a: return 32'h3f6e9a1c;
            default:      return t ^ 32'ha5a50f0f;
        endcase
    endfunction

    // Stub: done rises stub_lat cycles after the cycle following the
    // sin_reset strobe; optional stale high during the settle cycle.
    always @(posedge clk) begin
        if (sin_reset)          scnt <= 0;
        else if (scnt < 100000) scnt <= scnt + 1;
    end
    assign sin_done   = (scnt >= stub_lat) || (stale && scnt == 0);
    assign sin_result = sine_ref(sin_theta);

    assign req_valid = vld;
    always_comb begin
        req_theta = '0;
        req_prec  = '0;
        for (int i = 0; i < N; i++) begin
            req_theta[32*i +: 32] = th_a[i];
            req_prec[4*i +: 4]    = pr_a[i];
        end
    end

    function automatic int rr(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int w);
        if (w < 0) return 32'h0;
        return 32'h1 << w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One full transaction starting in an IDLE cycle.
    task automatic op(input int lat);
        int          w, rl;
        logic [31:0] th, er;
        logic [3:0]  pr;
        stub_lat = lat;
        w = rr(vld, last_g);
        @(negedge clk);
        chk("grant", 32'(req_ready), onehot(w));
        if (w < 0) begin
            @(posedge clk); #1;
            return;
        end
        last_g = w;
        th = th_a[w];
        pr = pr_a[w];
        rl = (lat <= TO) ? 3 + lat : 3 + TO;
        er = (lat <= TO) ? sine_ref(th) : 32'h0;
        @(posedge clk); #1;
        if (!sticky[w]) vld[w] = 1'b0;
        for (int c = 1; c <= rl; c++) begin
            @(negedge clk);
            chk("sin_reset", 32'(sin_reset), 32'(c == 1));
            chk("busy_ready", 32'(req_ready), 32'h0);
            chk("theta_hold", sin_theta, th);
            chk("rsp_valid", 32'(rsp_valid),
                (c == rl) ? onehot(w) : 32'h0);
            if (c == rl) begin
                chk("result", {rsp_result[31:3], 3'b0}, {er[31:3], 3'b0});
                chk("err", 32'(rsp_err), 32'(lat > TO));
                chk("prec", 32'(sin_prec), 32'(pr));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        th_a[0] = 32'h00000000; pr_a[0] = 4'ha;
        th_a[1] = 32'h3f800000; pr_a[1] = 4'h9;
        th_a[2] = 32'h3f99999a; pr_a[2] = 4'h7;
        th_a[3] = 32'h00000000; pr_a[3] = 4'ha;
        vld = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_sin_reset", 32'(sin_reset), 32'h1);
        chk("rst_theta", sin_theta, 32'h0);
        chk("rst_prec", 32'(sin_prec), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_g = N - 1;

        // all four from reset: order 0,1,2,3
        op(4); op(7); op(2); op(5);

        // single request from requester 1
        vld = 4'b0010; th_a[1] = 32'h3f800000; pr_a[1] = 4'h9;
        op(3);

        // fairness: 0 held, 2 joins
        sticky = 4'b0001; vld = 4'b0001;
        op(2);
        vld[2] = 1'b1; th_a[2] = 32'h12345678; pr_a[2] = 4'h3;
        op(3);
        op(2);
        vld[2] = 1'b1; th_a[2] = 32'h3f99999a;
        op(4);
        op(1);
        sticky = '0; vld = '0;

        // watchdog boundaries: never done, done on last cycle, one late
        vld = 4'b1000; th_a[3] = 32'h40490fdb;
        op(1000);
        vld = 4'b0100; th_a[2] = 32'h3f800000;
        op(TO);
        vld = 4'b0001; th_a[0] = 32'hbf000000;
        op(TO + 1);

        // stale done during settle must be ignored
        stale = 1'b1;
        vld = 4'b0010; th_a[1] = 32'h3f99999a;
        op(6);
        stale = 1'b0;

        // reset in the middle of WAIT
        vld = 4'b0100; th_a[2] = 32'h3f800000; stub_lat = 12;
        @(negedge clk);
        chk("mid_grant", 32'(req_ready), onehot(2));
        @(posedge clk); #1;
        vld = '0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_sin_reset", 32'(sin_reset), 32'h1);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_g = N - 1;
        @(negedge clk);
        chk("post_result", rsp_result, 32'h0);
        chk("post_err", 32'(rsp_err), 32'h0);
        chk("post_theta", sin_theta, 32'h0);
        chk("post_prec", 32'(sin_prec), 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_quiet", 32'(rsp_valid), 32'h0);
        end
        @(posedge clk); #1;
        vld = 4'b0011; th_a[0] = 32'h3f800000; th_a[1] = 32'h00000000;
        op(3);
        op(5);

        // randomized traffic
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    vld[i]  = 1'b1;
                    th_a[i] = $urandom;
                    pr_a[i] = 4'($urandom_range(0, 15));
                end
            end
            if (vld == '0) vld[$urandom_range(0, N - 1)] = 1'b1;
            op($urandom_range(1, TO + 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
